// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states and 8N1 frame constants
// used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   localparam int   FRAME_DATA_BITS = 8;
   localparam int   FRAME_STOP_BITS = 1;
   localparam logic START_LEVEL     = 1'b0;
   localparam logic STOP_LEVEL      = 1'b1;
   localparam logic IDLE_LEVEL      = 1'b1;

endpackage

// File: rtl/baud_gen.sv
// Free-running tick generator: one-cycle tick_baud every
// CLK_FREQ/BAUD_RATE clocks (truncated, minimum 1).
module baud_gen #(
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD_RATE = 115200
) (
   input  logic clk,
   input  logic rst,
   output logic tick_baud
);

   localparam int DIV_RAW = CLK_FREQ / BAUD_RATE;
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         tick_baud <= 1'b0;
      end else if (cnt == CW'(DIV - 1)) begin
         cnt       <= '0;
         tick_baud <= 1'b1;
      end else begin
         cnt       <= cnt + CW'(1);
         tick_baud <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with start-bit validation, mid-bit sampling
// and a valid/ready holding register reporting framing errors and overruns.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = FRAME_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   logic rx_m;
   logic rx_s;
   logic tick;

   rx_state_t            state;
   rx_state_t            state_n;
   logic [SW-1:0]        scnt;
   logic [SW-1:0]        scnt_n;
   logic [BW-1:0]        bidx;
   logic [BW-1:0]        bidx_n;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS-1:0] shreg_n;
   logic                 stop_ok;
   logic                 stop_bad;

   baud_gen #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE * OVERSAMPLE)
   ) u_baud (
      .clk       (clk),
      .rst       (rst),
      .tick_baud (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= IDLE_LEVEL;
         rx_s <= IDLE_LEVEL;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         scnt  <= '0;
         bidx  <= '0;
         shreg <= '0;
      end else begin
         state <= state_n;
         scnt  <= scnt_n;
         bidx  <= bidx_n;
         shreg <= shreg_n;
      end
   end

   always_comb begin
      state_n  = state;
      scnt_n   = scnt;
      bidx_n   = bidx;
      shreg_n  = shreg;
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
      if (tick) begin
         unique case (state)
            IDLE: begin
               if (rx_s == START_LEVEL) begin
                  state_n = START;
                  scnt_n  = '0;
               end
            end
            START: begin
               if (scnt == S_HALF) begin
                  scnt_n = '0;
                  if (rx_s == START_LEVEL) begin
                     state_n = DATA;
                     bidx_n  = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  scnt_n = scnt + SW'(1);
               end
            end
            DATA: begin
               if (scnt == S_LAST) begin
                  scnt_n  = '0;
                  shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                  bidx_n  = bidx + BW'(1);
                  if (bidx == B_LAST) state_n = STOP;
               end else begin
                  scnt_n = scnt + SW'(1);
               end
            end
            STOP: begin
               if (scnt == S_LAST) begin
                  scnt_n = '0;
                  if (rx_s == STOP_LEVEL) begin
                     stop_ok = 1'b1;
                     state_n = IDLE;
                  end else begin
                     stop_bad = 1'b1;
                     state_n  = WAIT_HIGH;
                  end
               end else begin
                  scnt_n = scnt + SW'(1);
               end
            end
            WAIT_HIGH: begin
               if (rx_s == IDLE_LEVEL) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // A same-cycle accept frees the holding register for the new byte
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= stop_ok && rx_valid && !rx_ready;
         if (stop_ok && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
